// File: rtl/cam_pkg.sv
// Shared types and pixel-format helpers for the camera capture path.
// Maps camera byte pairs to RGB888 and decodes the mode/decimation controls.
package cam_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_RGB565 = 2'b00,
        MODE_RGB444 = 2'b01,
        MODE_YUV_Y  = 2'b10
    } mode_e;

    function automatic mode_e decode_mode(logic [1:0] m);
        mode_e r;
        case (m)
            2'b01:   r = MODE_RGB444;
            2'b10:   r = MODE_YUV_Y;
            default: r = MODE_RGB565;
        endcase
        return r;
    endfunction

    // Low-bit mask on col/line; a pixel is kept when both masked values are zero.
    function automatic logic [1:0] decim_mask(logic [1:0] d);
        logic [1:0] r;
        case (d)
            2'd0:    r = 2'b00;
            2'd1:    r = 2'b01;
            default: r = 2'b11;
        endcase
        return r;
    endfunction

    function automatic logic [23:0] to_rgb888(mode_e mode, logic [7:0] b0, logic [7:0] b1);
        logic [23:0] r;
        logic [5:0]  g6;
        g6 = {b0[2:0], b1[7:5]};
        case (mode)
            MODE_RGB444: r = {b0[3:0], b0[3:0], b1[7:4], b1[7:4], b1[3:0], b1[3:0]};
            MODE_YUV_Y:  r = {b0, b0, b0};
            default:     r = {b0[7:3], b0[7:5], g6, g6[5:4], b1[4:0], b1[4:2]};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cam_capture_px_if.sv
// Camera byte stream in, frame-buffer write port out.
// The capture block uses the slave view; the camera/frame-buffer side uses master.
interface cam_capture_px_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              ivsync;
    logic              ihref;
    logic [7:0]        idata;
    logic              owr_en;
    logic [ADDR_W-1:0] oaddr;
    logic [23:0]       odata_out;

    modport master (
        output ivsync, ihref, idata,
        input  owr_en, oaddr, odata_out
    );

    modport slave (
        input  ivsync, ihref, idata,
        output owr_en, oaddr, odata_out
    );
endinterface

// File: rtl/cam_byte_pair.sv
// Pairs consecutive HREF-qualified bytes into one pixel.
// Outputs are registered, so a pixel appears one cycle after its second byte.
module cam_byte_pair (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       clr_i,
    input  logic       h_i,
    input  logic [7:0] d_i,
    output logic       phase_o,
    output logic       pix_valid_o,
    output logic [7:0] b0_o,
    output logic [7:0] b1_o
);
    logic       phase_q, phase_d;
    logic [7:0] hold_q, hold_d;
    logic       pix_q, pix_d;
    logic [7:0] b0_q, b0_d;
    logic [7:0] b1_q, b1_d;

    always_comb begin
        phase_d = (h_i && !clr_i) ? ~phase_q : 1'b0;
        hold_d  = (h_i && !phase_q) ? d_i : hold_q;
        pix_d   = en_i && h_i && phase_q;
        b0_d    = pix_d ? hold_q : b0_q;
        b1_d    = pix_d ? d_i : b1_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            phase_q <= 1'b0;
            hold_q  <= 8'h00;
            pix_q   <= 1'b0;
            b0_q    <= 8'h00;
            b1_q    <= 8'h00;
        end else begin
            phase_q <= phase_d;
            hold_q  <= hold_d;
            pix_q   <= pix_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
        end
    end

    assign phase_o     = phase_q;
    assign pix_valid_o = pix_q;
    assign b0_o        = b0_q;
    assign b1_o        = b1_q;
endmodule

// File: rtl/cam_capture_px.sv
// Camera capture: frame FSM, pixel/line counters, decimation, linear addressing
// and sticky geometry-error reporting on top of the byte pairer.
module cam_capture_px
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned ADDR_W   = 19
) (
    input  logic                   iclk,
    input  logic                   ireset,
    cam_capture_px_if.slave        cam,
    input  logic                   istart,
    input  logic                   icontinuous,
    input  logic [1:0]             imode,
    input  logic [1:0]             idecim,
    output logic                   obusy,
    output logic                   oframe_done,
    output logic                   oerr
);
    localparam int unsigned       CntW    = 16;
    localparam logic [CntW-1:0]   HMax    = CntW'(H_ACTIVE);
    localparam logic [CntW-1:0]   VMax    = CntW'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] AddrMax = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    logic              v_q, h_q, v_prev_q, h_prev_q;
    logic [7:0]        d_q;
    state_e            state_q, state_d;
    mode_e             mode_q, mode_d;
    logic [1:0]        mask_q, mask_d;
    logic [CntW-1:0]   col_q, col_d, line_q, line_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d, addr_q, addr_d;
    logic [23:0]       data_q, data_d;
    logic              wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic              frame_start, frame_end, h_fall, capturing, start_cap, keep, err_evt;
    logic [CntW-1:0]   col_next, line_next;
    logic              phase, pix_valid;
    logic [7:0]        pb0, pb1;

    cam_byte_pair u_byte_pair (
        .clk_i       (iclk),
        .rst_ni      (ireset),
        .en_i        (capturing),
        .clr_i       (start_cap),
        .h_i         (h_q),
        .d_i         (d_q),
        .phase_o     (phase),
        .pix_valid_o (pix_valid),
        .b0_o        (pb0),
        .b1_o        (pb1)
    );

    always_comb begin
        frame_start = v_prev_q && !v_q;
        frame_end   = !v_prev_q && v_q;
        h_fall      = h_prev_q && !h_q;
        capturing   = (state_q == CAPTURE);
        start_cap   = (state_q == WAIT_FRAME) && frame_start;

        // Saturating so oversized lines/frames never wrap back into range.
        col_next  = (pix_valid && col_q != '1) ? col_q + 1'b1 : col_q;
        line_next = (h_fall && line_q != '1) ? line_q + 1'b1 : line_q;

        keep = pix_valid && ((col_q[1:0] & mask_q) == 2'b00)
               && ((line_q[1:0] & mask_q) == 2'b00) && (col_q < HMax) && (line_q < VMax);

        err_evt = capturing && ((h_fall && (phase || col_next != HMax))
                                || (frame_end && line_next != VMax));

        state_d = state_q;
        mode_d  = mode_q;
        mask_d  = mask_q;
        col_d   = h_fall ? '0 : col_next;
        line_d  = line_next;
        waddr_d = (keep && waddr_q != AddrMax) ? waddr_q + 1'b1 : waddr_q;

        unique case (state_q)
            IDLE:       if (istart) state_d = WAIT_FRAME;
            WAIT_FRAME: if (frame_start) state_d = CAPTURE;
            CAPTURE:    if (frame_end) state_d = icontinuous ? WAIT_FRAME : IDLE;
            default:    state_d = IDLE;
        endcase

        if (start_cap) begin
            mode_d  = decode_mode(imode);
            mask_d  = decim_mask(idecim);
            col_d   = '0;
            line_d  = '0;
            waddr_d = '0;
        end

        wr_en_d = keep;
        addr_d  = keep ? waddr_q : addr_q;
        data_d  = keep ? to_rgb888(mode_q, pb0, pb1) : data_q;
        busy_d  = (state_d != IDLE);
        done_d  = capturing && frame_end;
        err_d   = (istart ? 1'b0 : err_q) | err_evt;
    end

    always_ff @(posedge iclk) begin
        if (!ireset) begin
            v_q      <= 1'b0;
            h_q      <= 1'b0;
            d_q      <= 8'h00;
            v_prev_q <= 1'b0;
            h_prev_q <= 1'b0;
            state_q  <= IDLE;
            mode_q   <= MODE_RGB565;
            mask_q   <= 2'b00;
            col_q    <= '0;
            line_q   <= '0;
            waddr_q  <= '0;
            addr_q   <= '0;
            data_q   <= 24'h0;
            wr_en_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            v_q      <= cam.ivsync;
            h_q      <= cam.ihref;
            d_q      <= cam.idata;
            v_prev_q <= v_q;
            h_prev_q <= h_q;
            state_q  <= state_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            col_q    <= col_d;
            line_q   <= line_d;
            waddr_q  <= waddr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_en_q  <= wr_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign cam.owr_en    = wr_en_q;
    assign cam.oaddr     = addr_q;
    assign cam.odata_out = data_q;
    assign obusy         = busy_q;
    assign oframe_done   = done_q;
    assign oerr          = err_q;
endmodule

// File: tb/tb_cam_capture_px.sv
// Scoreboard bench for cam_capture_px with an 8x4 frame: stimulus pushes expected
// writes, a negedge monitor pops and compares every owr_en strobe.
module tb_cam_capture_px;
    localparam int unsigned H  = 8;
    localparam int unsigned V  = 4;
    localparam int unsigned AW = 5;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [23:0]   data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n, istart, icont;
    logic [1:0] imode, idecim;
    logic       obusy, ofd, oerr;

    always #5 clk = ~clk;

    cam_capture_px_if #(.ADDR_W(AW)) cam ();

    cam_capture_px #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .ADDR_W   (AW)
    ) dut (
        .iclk        (clk),
        .ireset      (rst_n),
        .cam         (cam),
        .istart      (istart),
        .icontinuous (icont),
        .imode       (imode),
        .idecim      (idecim),
        .obusy       (obusy),
        .oframe_done (ofd),
        .oerr        (oerr)
    );

    wr_t        exp_q[$];
    wr_t        mon_e;
    int         n_cmp = 0, n_fail = 0, wr_cnt = 0, fd_cnt = 0;
    int         line_bytes[4];
    logic [7:0] pat0, pat1;
    logic [23:0] exp_const;
    bit         vary;
    int         exp_addr, tb_step, mid_mode;

    always @(negedge clk) begin
        if (ofd) fd_cnt++;
        if (cam.owr_en) begin
            wr_cnt++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%06h, want no write",
                         cam.oaddr, cam.odata_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (cam.oaddr !== mon_e.addr || cam.odata_out !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%0h data 0x%06h, want addr 0x%0h data 0x%06h",
                             cam.oaddr, cam.odata_out, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        istart = 1'b1;
        cyc(1);
        istart = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic push_expected(input int l, input int c, input logic [7:0] b0);
        wr_t e;
        if (c < H && l < V && (c % tb_step) == 0 && (l % tb_step) == 0) begin
            e.addr = AW'(exp_addr);
            e.data = vary ? {b0, b0, b0} : exp_const;
            exp_q.push_back(e);
            if (exp_addr < H * V - 1) exp_addr++;
        end
    endtask

    task automatic run_frame(input int nl);
        logic [7:0] b0;
        cam.ihref  = 1'b0;
        cam.ivsync = 1'b1;
        cyc(3);
        cam.ivsync = 1'b0;
        cyc(3);
        exp_addr = 0;
        for (int l = 0; l < nl; l++) begin
            for (int b = 0; b < line_bytes[l]; b++) begin
                b0 = vary ? {4'(l), 4'(b / 2)} : pat0;
                cam.ihref = 1'b1;
                cam.idata = (b % 2 == 0) ? b0 : pat1;
                if (b % 2 == 1) push_expected(l, b / 2, b0);
                cyc(1);
            end
            cam.ihref = 1'b0;
            cam.idata = 8'h00;
            cyc(3);
            if (mid_mode >= 0) begin
                imode    = 2'(mid_mode);
                mid_mode = -1;
            end
        end
        cam.ivsync = 1'b1;
        cyc(4);
    endtask

    task automatic setup(input logic [1:0] m, input logic [1:0] d, input logic [7:0] p0,
                         input logic [7:0] p1, input logic [23:0] ex, input bit v);
        imode     = m;
        idecim    = d;
        tb_step   = (d == 2'd0) ? 1 : (d == 2'd1) ? 2 : 4;
        pat0      = p0;
        pat1      = p1;
        exp_const = ex;
        vary      = v;
        for (int i = 0; i < 4; i++) line_bytes[i] = 16;
    endtask

    int w0, f0;

    initial begin
        rst_n = 1'b0; istart = 1'b0; icont = 1'b0; imode = 2'd0; idecim = 2'd0;
        cam.ivsync = 1'b1; cam.ihref = 1'b0; cam.idata = 8'h00;
        mid_mode = -1;
        cyc(3);
        check("rst_wr_en", cam.owr_en, 0);
        check("rst_addr", cam.oaddr, 0);
        check("rst_data", cam.odata_out, 0);
        check("rst_busy", obusy, 0);
        check("rst_frame_done", ofd, 0);
        check("rst_err", oerr, 0);
        rst_n = 1'b1;
        cyc(2);

        // RGB565 full frame, single shot
        setup(2'd0, 2'd0, 8'hF8, 8'h00, 24'hFF0000, 1'b0);
        w0 = wr_cnt; f0 = fd_cnt;
        pulse_start();
        check("busy_after_start", obusy, 1);
        run_frame(4);
        drain("rgb565_drain");
        check("rgb565_writes", wr_cnt - w0, 32);
        check("rgb565_frame_done", fd_cnt - f0, 1);
        check("rgb565_busy", obusy, 0);
        check("rgb565_err", oerr, 0);

        // RGB444 and YUV luma
        setup(2'd1, 2'd0, 8'h0A, 8'h5C, 24'hAA55CC, 1'b0);
        pulse_start(); run_frame(4);
        drain("rgb444_drain");
        setup(2'd2, 2'd0, 8'h80, 8'h10, 24'h808080, 1'b0);
        pulse_start(); run_frame(4);
        drain("yuv_drain");

        // Decimation with per-pixel luma tagging {line, col}
        setup(2'd2, 2'd1, 8'h00, 8'h33, 24'h0, 1'b1);
        w0 = wr_cnt;
        pulse_start(); run_frame(4);
        drain("decim1_drain");
        check("decim1_writes", wr_cnt - w0, 8);
        setup(2'd2, 2'd2, 8'h00, 8'h33, 24'h0, 1'b1);
        w0 = wr_cnt;
        pulse_start(); run_frame(4);
        drain("decim2_drain");
        check("decim2_writes", wr_cnt - w0, 2);

        // Bad line lengths: 15, 17 and 20 bytes
        setup(2'd0, 2'd0, 8'hF8, 8'h00, 24'hFF0000, 1'b0);
        line_bytes[0] = 15; line_bytes[1] = 17; line_bytes[2] = 20;
        w0 = wr_cnt;
        pulse_start(); run_frame(4);
        drain("badline_drain");
        check("badline_writes", wr_cnt - w0, 31);
        check("badline_err", oerr, 1);
        pulse_start();
        check("err_cleared", oerr, 0);
        setup(2'd0, 2'd0, 8'hF8, 8'h00, 24'hFF0000, 1'b0);
        run_frame(4);
        drain("clean_drain");
        check("clean_err", oerr, 0);

        // Short frame: 3 lines
        w0 = wr_cnt;
        pulse_start(); run_frame(3);
        drain("short_drain");
        check("short_writes", wr_cnt - w0, 24);
        check("short_err", oerr, 1);

        // Continuous: mode change mid frame 2 applies to frame 3
        icont = 1'b1;
        setup(2'd0, 2'd0, 8'hF8, 8'h00, 24'hFF0000, 1'b0);
        w0 = wr_cnt; f0 = fd_cnt;
        pulse_start(); run_frame(4);
        pat0 = 8'h0A; pat1 = 8'h5C; exp_const = 24'h0849E7; mid_mode = 1;
        run_frame(4);
        check("cont_busy_between", obusy, 1);
        icont = 1'b0;
        exp_const = 24'hAA55CC;
        run_frame(4);
        drain("cont_drain");
        check("cont_writes", wr_cnt - w0, 96);
        check("cont_frame_done", fd_cnt - f0, 3);
        check("cont_busy_end", obusy, 0);
        check("cont_err", oerr, 0);

        // Reset mid-line: pixels 0 and 1 reach the bus, pixel 2 is cancelled
        setup(2'd0, 2'd0, 8'hF8, 8'h00, 24'hFF0000, 1'b0);
        w0 = wr_cnt;
        pulse_start();
        cam.ivsync = 1'b1; cyc(3);
        cam.ivsync = 1'b0; cyc(3);
        tb_step = 1; exp_addr = 0;
        push_expected(0, 0, 8'hF8);
        push_expected(0, 1, 8'hF8);
        for (int b = 0; b < 7; b++) begin
            cam.ihref = 1'b1;
            cam.idata = (b % 2 == 0) ? 8'hF8 : 8'h00;
            cyc(1);
        end
        rst_n = 1'b0;
        cyc(1);
        check("mrst_wr_en", cam.owr_en, 0);
        check("mrst_addr", cam.oaddr, 0);
        check("mrst_data", cam.odata_out, 0);
        check("mrst_busy", obusy, 0);
        check("mrst_err", oerr, 0);
        rst_n = 1'b1;
        for (int b = 0; b < 9; b++) cyc(1);
        cam.ihref = 1'b0; cyc(3);
        cam.ivsync = 1'b1; cyc(3);
        cam.ivsync = 1'b0; cyc(4);
        for (int b = 0; b < 16; b++) begin
            cam.ihref = 1'b1;
            cam.idata = (b % 2 == 0) ? 8'hF8 : 8'h00;
            cyc(1);
        end
        cam.ihref = 1'b0; cyc(3);
        drain("mrst_drain");
        check("mrst_writes", wr_cnt - w0, 2);
        check("mrst_idle", obusy, 0);
        w0 = wr_cnt;
        pulse_start(); run_frame(4);
        drain("after_rst_drain");
        check("after_rst_writes", wr_cnt - w0, 32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
